// File: rtl/la_clkgate_ctrl.sv
// Clock-gate enable controller: per-branch OFF/WAKE/ON/IDLE FSM sharing a single wake slot.
// Latency: req sampled on a rising edge; en/ack/busy are registered and show that edge's decision.
// Backpressure: unchosen requesters hold in OFF (en=0) until round-robin hands them the wake slot.
module la_clkgate_ctrl #(
    parameter int N    = 4,
    parameter int CNTW = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    req,
    input  logic [CNTW-1:0] wake_delay,
    input  logic [CNTW-1:0] idle_limit,
    output logic [N-1:0]    en,
    output logic [N-1:0]    ack,
    output logic            busy
);

    localparam int PW = $clog2(N);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_IDLE = 2'd3;

    logic [1:0]      state_q    [N];
    logic [1:0]      state_d    [N];
    logic [CNTW-1:0] idle_cnt_q [N];
    logic [CNTW-1:0] idle_cnt_d [N];
    logic [CNTW-1:0] wake_cnt_q, wake_cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]    en_q, en_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            busy_q, busy_d;

    logic            wake_active;
    logic            slot_free;
    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;

    // Wake-slot arbitration: the slot frees when nobody wakes or the waker finishes this edge,
    // so consecutive wakes chain with no gap; search starts at the round-robin pointer.
    always_comb begin
        logic [PW:0] cand;
        cand        = '0;
        wake_active = 1'b0;
        gnt_vld     = 1'b0;
        gnt_idx     = '0;
        for (int i = 0; i < N; i++) begin
            if (state_q[i] == ST_WAKE) begin
                wake_active = 1'b1;
            end
        end
        slot_free = !wake_active || (wake_cnt_q == '0);
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            if (slot_free && !gnt_vld && req[cand[PW-1:0]] &&
                (state_q[cand[PW-1:0]] == ST_OFF)) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
    end

    // Next state for the shared wake counter, the pointer, each branch FSM and the output flops.
    always_comb begin
        wake_cnt_d = wake_cnt_q;
        if (gnt_vld) begin
            wake_cnt_d = wake_delay;
        end else if (wake_active && (wake_cnt_q != '0)) begin
            wake_cnt_d = wake_cnt_q - CNTW'(1);
        end

        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);
        end

        en_d   = '0;
        ack_d  = '0;
        busy_d = 1'b0;
        for (int i = 0; i < N; i++) begin
            state_d[i]    = state_q[i];
            idle_cnt_d[i] = idle_cnt_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (gnt_vld && (gnt_idx == PW'(i))) begin
                        state_d[i] = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    // A dropped req does not abort the wake; the branch settles to ON first.
                    if (wake_cnt_q == '0) begin
                        state_d[i] = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!req[i]) begin
                        state_d[i]    = ST_IDLE;
                        idle_cnt_d[i] = idle_limit;
                    end
                end
                default: begin
                    // IDLE: a returning request resumes ON with the clock still valid.
                    if (req[i]) begin
                        state_d[i] = ST_ON;
                    end else if (idle_cnt_q[i] == '0) begin
                        state_d[i] = ST_OFF;
                    end else begin
                        idle_cnt_d[i] = idle_cnt_q[i] - CNTW'(1);
                    end
                end
            endcase
            en_d[i]  = (state_d[i] != ST_OFF);
            ack_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_IDLE);
            if (state_d[i] == ST_WAKE) begin
                busy_d = 1'b1;
            end
        end
    end

    // State and output registers; reset forces every branch OFF immediately.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i]    <= ST_OFF;
                idle_cnt_q[i] <= '0;
            end
            wake_cnt_q <= '0;
            ptr_q      <= '0;
            en_q       <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i]    <= state_d[i];
                idle_cnt_q[i] <= idle_cnt_d[i];
            end
            wake_cnt_q <= wake_cnt_d;
            ptr_q      <= ptr_d;
            en_q       <= en_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    // PROP picks the technology flavour of the enable path; every flavour currently
    // hands the registered enable straight to the gate cells.
    generate
        if (PROP == "DEFAULT") begin : g_en_default
            assign en = en_q;
        end else begin : g_en_tech
            assign en = en_q;
        end
    endgenerate

    assign ack  = ack_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_la_clkgate_ctrl.sv
module tb_la_clkgate_ctrl;

    typedef struct {
        logic [3:0] req;
        logic [7:0] wd;
        logic [7:0] il;
        logic [3:0] en;
        logic [3:0] ack;
        logic       busy;
    } cyc_t;

    logic       clk;
    logic       nreset;
    logic [3:0] req;
    logic [7:0] wake_delay;
    logic [7:0] idle_limit;
    logic [3:0] en;
    logic [3:0] ack;
    logic       busy;

    int   n_checks;
    int   n_errors;
    cyc_t exp_q [$];

    la_clkgate_ctrl #(.N(4), .CNTW(8), .PROP("DEFAULT")) dut (
        .clk       (clk),
        .nreset    (nreset),
        .req       (req),
        .wake_delay(wake_delay),
        .idle_limit(idle_limit),
        .en        (en),
        .ack       (ack),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // One table row: inputs applied before an edge, outputs expected just after it.
    function automatic cyc_t cy(logic [3:0] r, int w, int i, logic [3:0] e, logic [3:0] a, logic b);
        cyc_t c;
        c.req  = r;
        c.wd   = 8'(w);
        c.il   = 8'(i);
        c.en   = e;
        c.ack  = a;
        c.busy = b;
        return c;
    endfunction

    task automatic test_reset;
        nreset     = 1'b0;
        req        = 4'b0000;
        wake_delay = 8'd0;
        idle_limit = 8'd0;
        #1;
        n_checks++;
        if (en !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_initial: en=%b ack=%b busy=%b, expected en=0000 ack=0000 busy=0", en, ack, busy);
        end
        req = 4'b1111;
        @(posedge clk); #1;
        n_checks++;
        if (en !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_held_with_req: en=%b ack=%b busy=%b, expected en=0000 ack=0000 busy=0", en, ack, busy);
        end
        req = 4'b0000;
        @(negedge clk);
        nreset = 1'b1;
    endtask

    // Branch 0 alone, wake_delay=3 (changed mid-count to 9, which must be ignored).
    task automatic test_basic_wake;
        cyc_t tbl [$];
        cyc_t e;
        tbl.push_back(cy(4'b0001, 3, 0, 4'b0001, 4'b0000, 1'b1));
        repeat (3) tbl.push_back(cy(4'b0001, 9, 0, 4'b0001, 4'b0000, 1'b1));
        repeat (2) tbl.push_back(cy(4'b0001, 9, 0, 4'b0001, 4'b0001, 1'b0));
        foreach (tbl[k]) begin
            req = tbl[k].req; wake_delay = tbl[k].wd; idle_limit = tbl[k].il;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (en !== e.en || ack !== e.ack || busy !== e.busy) begin
                n_errors++;
                $display("FAIL basic_wake cyc %0d: en=%b ack=%b busy=%b, expected en=%b ack=%b busy=%b",
                         k + 1, en, ack, busy, e.en, e.ack, e.busy);
            end
        end
    endtask

    // Idle timeout of 5 (limit changed mid-count), re-wake via pointer wrap, re-assert at idle cycle 3.
    task automatic test_idle_timeout;
        cyc_t tbl [$];
        cyc_t e;
        tbl.push_back(cy(4'b0000, 0, 5, 4'b0001, 4'b0001, 1'b0));
        repeat (5) tbl.push_back(cy(4'b0000, 0, 1, 4'b0001, 4'b0001, 1'b0));
        tbl.push_back(cy(4'b0000, 0, 1, 4'b0000, 4'b0000, 1'b0));
        repeat (4) tbl.push_back(cy(4'b0001, 3, 5, 4'b0001, 4'b0000, 1'b1));
        tbl.push_back(cy(4'b0001, 3, 5, 4'b0001, 4'b0001, 1'b0));
        repeat (3) tbl.push_back(cy(4'b0000, 3, 5, 4'b0001, 4'b0001, 1'b0));
        repeat (7) tbl.push_back(cy(4'b0001, 3, 5, 4'b0001, 4'b0001, 1'b0));
        tbl.push_back(cy(4'b0000, 0, 0, 4'b0001, 4'b0001, 1'b0));
        tbl.push_back(cy(4'b0000, 0, 0, 4'b0000, 4'b0000, 1'b0));
        foreach (tbl[k]) begin
            req = tbl[k].req; wake_delay = tbl[k].wd; idle_limit = tbl[k].il;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (en !== e.en || ack !== e.ack || busy !== e.busy) begin
                n_errors++;
                $display("FAIL idle_timeout cyc %0d: en=%b ack=%b busy=%b, expected en=%b ack=%b busy=%b",
                         k + 1, en, ack, busy, e.en, e.ack, e.busy);
            end
        end
    endtask

    // After reset (pointer 0), all four request at once with wake_delay=2: wakes 0,1,2,3 back to back.
    task automatic test_back_to_back;
        cyc_t tbl [$];
        cyc_t e;
        int   b;
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            b = (c - 1) / 3;
            tbl.push_back(cy(4'b1111, 2, 0, 4'((1 << (b + 1)) - 1), 4'((1 << b) - 1), 1'b1));
        end
        repeat (2) tbl.push_back(cy(4'b1111, 2, 0, 4'b1111, 4'b1111, 1'b0));
        foreach (tbl[k]) begin
            req = tbl[k].req; wake_delay = tbl[k].wd; idle_limit = tbl[k].il;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (en !== e.en || ack !== e.ack || busy !== e.busy) begin
                n_errors++;
                $display("FAIL back_to_back cyc %0d: en=%b ack=%b busy=%b, expected en=%b ack=%b busy=%b",
                         k + 1, en, ack, busy, e.en, e.ack, e.busy);
            end
        end
    endtask

    // Drop everything, wake branch 2 to move the pointer to 3, then 3,0,1 pending: order must be 3,0,1.
    task automatic test_fairness_wrap;
        cyc_t tbl [$];
        cyc_t e;
        tbl.push_back(cy(4'b0000, 0, 0, 4'b1111, 4'b1111, 1'b0));
        tbl.push_back(cy(4'b0000, 0, 0, 4'b0000, 4'b0000, 1'b0));
        tbl.push_back(cy(4'b0100, 0, 0, 4'b0100, 4'b0000, 1'b1));
        tbl.push_back(cy(4'b0100, 0, 0, 4'b0100, 4'b0100, 1'b0));
        repeat (2) tbl.push_back(cy(4'b1111, 1, 0, 4'b1100, 4'b0100, 1'b1));
        repeat (2) tbl.push_back(cy(4'b1111, 1, 0, 4'b1101, 4'b1100, 1'b1));
        repeat (2) tbl.push_back(cy(4'b1111, 1, 0, 4'b1111, 4'b1101, 1'b1));
        tbl.push_back(cy(4'b1111, 1, 0, 4'b1111, 4'b1111, 1'b0));
        foreach (tbl[k]) begin
            req = tbl[k].req; wake_delay = tbl[k].wd; idle_limit = tbl[k].il;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (en !== e.en || ack !== e.ack || busy !== e.busy) begin
                n_errors++;
                $display("FAIL fairness_wrap cyc %0d: en=%b ack=%b busy=%b, expected en=%b ack=%b busy=%b",
                         k + 1, en, ack, busy, e.en, e.ack, e.busy);
            end
        end
    endtask

    // wake_delay=0 / idle_limit=0 with a one-cycle req pulse, then a two-branch chain from pointer 2.
    task automatic test_boundaries;
        cyc_t tbl [$];
        cyc_t e;
        tbl.push_back(cy(4'b0000, 0, 0, 4'b1111, 4'b1111, 1'b0));
        tbl.push_back(cy(4'b0000, 0, 0, 4'b0000, 4'b0000, 1'b0));
        tbl.push_back(cy(4'b0010, 0, 0, 4'b0010, 4'b0000, 1'b1));
        tbl.push_back(cy(4'b0000, 0, 0, 4'b0010, 4'b0010, 1'b0));
        tbl.push_back(cy(4'b0000, 0, 0, 4'b0010, 4'b0010, 1'b0));
        tbl.push_back(cy(4'b0000, 0, 0, 4'b0000, 4'b0000, 1'b0));
        tbl.push_back(cy(4'b0011, 0, 0, 4'b0001, 4'b0000, 1'b1));
        tbl.push_back(cy(4'b0011, 0, 0, 4'b0011, 4'b0001, 1'b1));
        tbl.push_back(cy(4'b0011, 0, 0, 4'b0011, 4'b0011, 1'b0));
        tbl.push_back(cy(4'b0000, 0, 0, 4'b0011, 4'b0011, 1'b0));
        tbl.push_back(cy(4'b0000, 0, 0, 4'b0000, 4'b0000, 1'b0));
        foreach (tbl[k]) begin
            req = tbl[k].req; wake_delay = tbl[k].wd; idle_limit = tbl[k].il;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (en !== e.en || ack !== e.ack || busy !== e.busy) begin
                n_errors++;
                $display("FAIL boundaries cyc %0d: en=%b ack=%b busy=%b, expected en=%b ack=%b busy=%b",
                         k + 1, en, ack, busy, e.en, e.ack, e.busy);
            end
        end
    endtask

    // Branch 2 waking with count 1 left when reset hits between edges; then a full 4-cycle re-wake.
    task automatic test_reset_mid_wake;
        cyc_t tbl [$];
        cyc_t e;
        tbl.push_back(cy(4'b0100, 3, 0, 4'b0100, 4'b0000, 1'b1));
        repeat (2) tbl.push_back(cy(4'b0100, 3, 0, 4'b0100, 4'b0000, 1'b1));
        foreach (tbl[k]) begin
            req = tbl[k].req; wake_delay = tbl[k].wd; idle_limit = tbl[k].il;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (en !== e.en || ack !== e.ack || busy !== e.busy) begin
                n_errors++;
                $display("FAIL reset_mid_wake_pre cyc %0d: en=%b ack=%b busy=%b, expected en=%b ack=%b busy=%b",
                         k + 1, en, ack, busy, e.en, e.ack, e.busy);
            end
        end
        #2;
        nreset = 1'b0;
        #1;
        n_checks++;
        if (en !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: en=%b ack=%b busy=%b, expected en=0000 ack=0000 busy=0", en, ack, busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (en !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: en=%b ack=%b busy=%b, expected en=0000 ack=0000 busy=0", en, ack, busy);
        end
        @(negedge clk);
        nreset = 1'b1;
        tbl.delete();
        tbl.push_back(cy(4'b0100, 3, 0, 4'b0100, 4'b0000, 1'b1));
        repeat (3) tbl.push_back(cy(4'b0100, 7, 0, 4'b0100, 4'b0000, 1'b1));
        repeat (2) tbl.push_back(cy(4'b0100, 7, 0, 4'b0100, 4'b0100, 1'b0));
        foreach (tbl[k]) begin
            req = tbl[k].req; wake_delay = tbl[k].wd; idle_limit = tbl[k].il;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (en !== e.en || ack !== e.ack || busy !== e.busy) begin
                n_errors++;
                $display("FAIL reset_mid_wake_post cyc %0d: en=%b ack=%b busy=%b, expected en=%b ack=%b busy=%b",
                         k + 1, en, ack, busy, e.en, e.ack, e.busy);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic_wake();
        test_idle_timeout();
        test_back_to_back();
        test_fairness_wrap();
        test_boundaries();
        test_reset_mid_wake();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/la_clkgate_ctrl.md
LA_CLKGATE_CTRL -- requirements
Module: la_clkgate_ctrl

Interface
REQ-001 Parameter N, default 4, number of gated clock branches controlled (N>=2).
REQ-002 Parameter CNTW, default 8, width of wake and idle counters.
REQ-003 Parameter PROP, default "DEFAULT", implementation property passed through to technology cells.
REQ-004 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 nreset  input  1  asynchronous, active-low reset.
REQ-006 req  input  N  per-branch clock request, level, sampled at clk rising edge.
REQ-007 wake_delay  input  CNTW  settle cycles after enabling a branch.
REQ-008 idle_limit  input  CNTW  hold-off cycles before disabling an unrequested branch.
REQ-009 en  output  N  per-branch clock-gate enable, registered, to be ORed or ANDed into the clock-gate cells.
REQ-010 ack  output  N  per-branch clock-valid acknowledge, registered.
REQ-011 busy  output  1  high while any branch is in WAKE, registered.

Function
REQ-012 Each branch SHALL own a 4-state FSM: OFF, WAKE, ON, IDLE.
REQ-013 Outputs per branch: OFF en=0/ack=0; WAKE en=1/ack=0; ON en=1/ack=1; IDLE en=1/ack=1.
REQ-014 At most one branch SHALL be in WAKE at any time (inrush limit).
REQ-015 Wake slot is free at an edge when no branch is in WAKE, or the WAKE branch has wake counter == 0 (completing that edge); back-to-back wakes SHALL have no gap cycle.
REQ-016 When the slot is free, the controller SHALL grant one OFF branch with req=1: lowest index at or above the round-robin pointer, wrapping modulo N.
REQ-017 On grant, the granted branch goes OFF->WAKE, the wake counter loads wake_delay, and the pointer SHALL become (granted index + 1) mod N.
REQ-018 Pointer SHALL be unchanged on edges with no grant.
REQ-019 In WAKE: wake counter == 0 -> ON next edge; else decrement. WAKE therefore lasts wake_delay+1 cycles (wake_delay=0 gives 1 cycle).
REQ-020 req deasserted during WAKE SHALL NOT abort the wake; the branch completes to ON and then follows ON rules.
REQ-021 In ON: req=0 -> IDLE with the branch idle counter loaded with idle_limit; req=1 -> stay ON.
REQ-022 In IDLE: req=1 -> ON (ack stays 1, no re-wake). Otherwise, idle counter == 0 -> OFF; else decrement.
REQ-023 en and ack SHALL fall on the same edge. en is high for idle_limit+1 cycles after the edge that entered IDLE.
REQ-024 wake_delay and idle_limit SHALL be sampled only when loaded; changes mid-count SHALL NOT affect a running count.
REQ-025 busy SHALL equal OR over branches of (state == WAKE).
REQ-026 A branch in OFF with req=0 SHALL never be granted. An unchosen requester SHALL wait in OFF with en=0.
REQ-027 Round-robin SHALL guarantee each requesting branch a grant within N wake slots.

Reset
REQ-028 While nreset=0, all branches SHALL be OFF, en=0, ack=0, busy=0, pointer=0, and all counters 0, asynchronously.
REQ-029 Reset asserted mid-WAKE or mid-IDLE SHALL force OFF immediately. After release, branches re-request normally, with the first grant no earlier than the first rising edge after nreset rises.

Verification
REQ-030 Basic wake: N=4, wake_delay=3, req[0]=1 from edge 0 -> en[0]=1 after edge 1, busy=1 for 4 cycles, ack[0]=1 after edge 5.
REQ-031 Idle timeout: branch 0 ON, idle_limit=5, req[0] falls -> en[0] and ack[0] fall together 6 cycles after IDLE entry. Re-assert req[0] at idle cycle 3 -> stays ON, ack never drops.
REQ-032 Arbitration: req=4'b1111 simultaneously, pointer=0, wake_delay=2 -> WAKE order 0,1,2,3, each 3 cycles, no gaps, never two branches in WAKE, all ack high after 12 cycles.
REQ-033 Fairness/wrap: pointer=3, req[3] and req[0] pending -> 3 is granted then 0; a persistent req[1] is granted within 4 slots.
REQ-034 Boundaries: wake_delay=0 and idle_limit=0 -> WAKE 1 cycle, IDLE 1 cycle. req pulse of 1 cycle during WAKE -> completes to ON, then IDLE, then OFF.
REQ-035 Reset: nreset low mid-WAKE with branch 2 at count 1 -> en=0, ack=0, busy=0 without a clock edge. After release with req[2]=1 -> full wake_delay+1 wake sequence.
